mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single 16-bit physical memory port (read/write/byte-enable/address/wdata/resp/rdata) between two requesters inside mp3:
  - the instruction-fetch port (read-only);
  - the data port (read/write).
- Sits between the mp3 core and the memory model.
- Grants one requester at a time, latches that request, and forwards it downstream until mem_resp.
- Routes the response back to the granted requester only.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- BE_W, 2, byte-enable width (DATA_W/8).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- i_read  in  1  instruction fetch request.
- i_address  in  ADDR_W  fetch address.
- i_resp  out  1  fetch complete, one-cycle pulse.
- i_rdata  out  DATA_W  fetch data, valid when i_resp=1.
- d_read  in  1  data read request.
- d_write  in  1  data write request.
- d_byte_enable  in  BE_W  write byte mask.
- d_address  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_resp  out  1  data access complete, one-cycle pulse.
- d_rdata  out  DATA_W  read data, valid when d_resp=1.
- mem_read  out  1  downstream read.
- mem_write  out  1  downstream write.
- mem_byte_enable  out  BE_W  downstream mask.
- mem_address  out  ADDR_W  downstream address.
- mem_wdata  out  DATA_W  downstream write data.
- mem_resp  in  1  downstream completion.
- mem_rdata  in  DATA_W  downstream read data.

Behaviour:
- States: ARB_IDLE, ARB_IMEM, ARB_DMEM. Registers:
  - state;
  - last_grant (I or D);
  - latched op_read, op_write, be, addr, wdata.
- Reset (rst=1 at edge):
  - state=ARB_IDLE, last_grant=I, latches cleared to 0.
  - Next cycle: mem_read=0, mem_write=0, mem_address=0, mem_wdata=0, mem_byte_enable=0, i_resp=0, d_resp=0.
  - Reset mid-transaction abandons it; a mem_resp arriving while in ARB_IDLE is ignored.
- ARB_IDLE transitions:
  - Only i_read → ARB_IMEM; latch i_address, op_read=1, op_write=0, be=all ones.
  - Only d_read or d_write → ARB_DMEM; latch d_* signals.
  - d_read and d_write both high is a protocol violation and is treated as a write.
  - Both ports requesting → round robin: grant the port not in last_grant (first tie after reset goes to D).
  - On a grant, last_grant updates to the granted port.
- Downstream outputs:
  - In ARB_IMEM/ARB_DMEM, mem_* are driven only from the latched registers, never combinationally from requester inputs.
  - In ARB_IDLE, mem_read=mem_write=0.
- Arbitration latency: a request seen at edge N appears on mem_read/mem_write in cycle N+1.
- Completion:
  - In a busy state, mem_resp=1 drives the granted port's resp=1 combinationally in the same cycle; the other resp stays 0.
  - i_rdata and d_rdata both equal mem_rdata continuously; they are only meaningful with their resp.
  - On that edge, state → ARB_IDLE.
  - There is exactly one ARB_IDLE cycle between back-to-back transactions, so the requester can drop its request after its resp.
- A requester dropping its request before resp does not abort the access: the transaction completes and the resp pulse is still issued.
- A request changing while not granted has no effect on the in-flight latched transaction.
- No timeout; the arbiter waits indefinitely for mem_resp.

Decomposition:
- Package mem_arb_pkg:
  - typedef enum arb_state_t {ARB_IDLE, ARB_IMEM, ARB_DMEM};
  - typedef enum grant_t {GRANT_I, GRANT_D};
  - localparams ADDR_W, DATA_W, BE_W defaults.
- One natural sub-module, mem_arb_req_reg: load-enabled register bundle holding op_read, op_write, be, addr, wdata, with synchronous clear.
- FSM, round-robin logic and response demux stay in mem_arbiter.

Test Plan:
- Reset: hold rst=1 for 2 cycles with i_read=1 → mem_read=0, mem_write=0, i_resp=0, d_resp=0; after release, mem_read=1 with mem_address=i_address in the next cycle.
- Single fetch: i_read=1, i_address=0x0040; memory returns 0x1234 after 3 cycles → mem_read=1, mem_address=0x0040, mem_byte_enable=2'b11, i_resp pulses 1 cycle with i_rdata=0x1234, d_resp stays 0.
- Write: d_write=1, d_address=0x8002, d_wdata=0xBEEF, d_byte_enable=2'b10 → mem_write=1 with identical latched values; after d_resp, memory[0x8002] high byte=0xBE, low byte unchanged.
- Tie and fairness: i_read and d_read held high continuously from reset, each dropping one cycle after its resp, then re-asserting → grant order D, I, D, I; exactly one idle cycle between grants.
- Latch stability: after a D grant to 0x1000, change d_address to 0x2000 mid-transaction → mem_address stays 0x1000 until mem_resp.
- Reset mid-op: assert rst during ARB_DMEM before mem_resp → state ARB_IDLE, mem_write=0 next cycle, no d_resp pulse for the abandoned access.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the two-port memory arbiter.
// Grants the instruction-fetch or data requester one memory port at a time.
package mem_arb_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned BE_W   = DATA_W / 8;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_IMEM,
        ARB_DMEM
    } arb_state_t;

    typedef enum logic {
        GRANT_I,
        GRANT_D
    } grant_t;

endpackage

// File: rtl/mem_arb_req_reg.sv
// Holds the granted request. A load captures a new request, and a synchronous
// clear zeroes every field.
module mem_arb_req_reg #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned BE_W   = 2
) (
    input  logic              clk_i,
    input  logic              clr_i,
    input  logic              load_i,
    input  logic              op_read_i,
    input  logic              op_write_i,
    input  logic [BE_W-1:0]   be_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              op_read_o,
    output logic              op_write_o,
    output logic [BE_W-1:0]   be_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] wdata_o
);

    logic              op_read_q, op_read_d;
    logic              op_write_q, op_write_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    always_comb begin
        op_read_d  = op_read_q;
        op_write_d = op_write_q;
        be_d       = be_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if (load_i) begin
            op_read_d  = op_read_i;
            op_write_d = op_write_i;
            be_d       = be_i;
            addr_d     = addr_i;
            wdata_d    = wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            op_read_q  <= 1'b0;
            op_write_q <= 1'b0;
            be_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            op_read_q  <= op_read_d;
            op_write_q <= op_write_d;
            be_q       <= be_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign op_read_o  = op_read_q;
    assign op_write_o = op_write_q;
    assign be_o       = be_q;
    assign addr_o     = addr_q;
    assign wdata_o    = wdata_q;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between the fetch and data requesters.
// The arbiter uses round-robin on ties, forwards the latched request, and routes the response.
module mem_arbiter #(
    parameter int unsigned ADDR_W = mem_arb_pkg::ADDR_W,
    parameter int unsigned DATA_W = mem_arb_pkg::DATA_W,
    parameter int unsigned BE_W   = mem_arb_pkg::BE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic              i_resp,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [BE_W-1:0]   d_byte_enable,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_resp,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [BE_W-1:0]   mem_byte_enable,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_resp,
    input  logic [DATA_W-1:0] mem_rdata
);

    import mem_arb_pkg::*;

    arb_state_t state_q, state_d;
    grant_t     last_grant_q, last_grant_d;

    logic              d_req, pick_i, pick_d, busy;
    logic              load;
    logic              ld_read, ld_write;
    logic [BE_W-1:0]   ld_be;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic              op_read, op_write;
    logic [BE_W-1:0]   op_be;
    logic [ADDR_W-1:0] op_addr;
    logic [DATA_W-1:0] op_wdata;

    assign d_req  = d_read | d_write;
    // On a tie, the port that was not granted last wins.
    assign pick_d = d_req && (!i_read || last_grant_q == GRANT_I);
    assign pick_i = i_read && (!d_req || last_grant_q == GRANT_D);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        load         = 1'b0;
        ld_read      = 1'b0;
        ld_write     = 1'b0;
        ld_be        = '0;
        ld_addr      = '0;
        ld_wdata     = '0;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_d) begin
                    state_d      = ARB_DMEM;
                    last_grant_d = GRANT_D;
                    load         = 1'b1;
                    // A simultaneous read and write is treated as a write.
                    ld_read      = d_read & ~d_write;
                    ld_write     = d_write;
                    ld_be        = d_byte_enable;
                    ld_addr      = d_address;
                    ld_wdata     = d_wdata;
                end else if (pick_i) begin
                    state_d      = ARB_IMEM;
                    last_grant_d = GRANT_I;
                    load         = 1'b1;
                    ld_read      = 1'b1;
                    ld_be        = '1;
                    ld_addr      = i_address;
                end
            end
            ARB_IMEM, ARB_DMEM: begin
                if (mem_resp) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= GRANT_I;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    mem_arb_req_reg #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .BE_W   (BE_W)
    ) u_req_reg (
        .clk_i      (clk),
        .clr_i      (rst),
        .load_i     (load),
        .op_read_i  (ld_read),
        .op_write_i (ld_write),
        .be_i       (ld_be),
        .addr_i     (ld_addr),
        .wdata_i    (ld_wdata),
        .op_read_o  (op_read),
        .op_write_o (op_write),
        .be_o       (op_be),
        .addr_o     (op_addr),
        .wdata_o    (op_wdata)
    );

    assign busy            = (state_q != ARB_IDLE);
    assign mem_read        = busy & op_read;
    assign mem_write       = busy & op_write;
    assign mem_byte_enable = op_be;
    assign mem_address     = op_addr;
    assign mem_wdata       = op_wdata;

    assign i_resp  = (state_q == ARB_IMEM) & mem_resp;
    assign d_resp  = (state_q == ARB_DMEM) & mem_resp;
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a scoreboard queue of expected responses is
// popped on each resp pulse; inputs change 1 time unit after posedge and are sampled at negedge.
module tb_mem_arbiter;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned BE_W   = 2;

    logic              clk;
    logic              rst;
    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic              i_resp;
    logic [DATA_W-1:0] i_rdata;
    logic              d_read;
    logic              d_write;
    logic [BE_W-1:0]   d_byte_enable;
    logic [ADDR_W-1:0] d_address;
    logic [DATA_W-1:0] d_wdata;
    logic              d_resp;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_read;
    logic              mem_write;
    logic [BE_W-1:0]   mem_byte_enable;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_resp;
    logic [DATA_W-1:0] mem_rdata;

    typedef struct {
        bit          is_d;
        bit          chk_data;
        logic [15:0] data;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] mem_word;

    mem_arbiter dut (
        .clk             (clk),
        .rst             (rst),
        .i_read          (i_read),
        .i_address       (i_address),
        .i_resp          (i_resp),
        .i_rdata         (i_rdata),
        .d_read          (d_read),
        .d_write         (d_write),
        .d_byte_enable   (d_byte_enable),
        .d_address       (d_address),
        .d_wdata         (d_wdata),
        .d_resp          (d_resp),
        .d_rdata         (d_rdata),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_resp        (mem_resp),
        .mem_rdata       (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input bit is_d, input bit chk_data, input logic [15:0] data);
        exp_t e;
        e.is_d     = is_d;
        e.chk_data = chk_data;
        e.data     = data;
        sb.push_back(e);
    endtask

    // Called at the negedge of a cycle where mem_resp is high.
    task automatic expect_resp(input string tag);
        exp_t e;
        check({tag, "_sb_nonempty"}, {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_i_resp"}, {31'd0, i_resp}, {31'd0, !e.is_d});
            check({tag, "_d_resp"}, {31'd0, d_resp}, {31'd0, e.is_d});
            if (e.chk_data) begin
                if (e.is_d) check({tag, "_d_rdata"}, {16'd0, d_rdata}, {16'd0, e.data});
                else        check({tag, "_i_rdata"}, {16'd0, i_rdata}, {16'd0, e.data});
            end
        end
    endtask

    initial begin
        rst           = 1'b1;
        i_read        = 1'b1;
        i_address     = 16'h0040;
        d_read        = 1'b0;
        d_write       = 1'b0;
        d_byte_enable = 2'b00;
        d_address     = 16'h0000;
        d_wdata       = 16'h0000;
        mem_resp      = 1'b0;
        mem_rdata     = 16'h0000;
        mem_word      = 16'h1155;

        // Reset held with a fetch pending: nothing reaches memory.
        step();
        at_neg();
        check("rst_mem_read", {31'd0, mem_read}, 32'd0);
        check("rst_mem_write", {31'd0, mem_write}, 32'd0);
        check("rst_mem_address", {16'd0, mem_address}, 32'd0);
        check("rst_mem_be", {30'd0, mem_byte_enable}, 32'd0);
        check("rst_i_resp", {31'd0, i_resp}, 32'd0);
        check("rst_d_resp", {31'd0, d_resp}, 32'd0);
        step();
        at_neg();
        check("rst2_mem_read", {31'd0, mem_read}, 32'd0);
        step();
        rst = 1'b0;

        // Single fetch: granted at the first edge after release, 3-cycle memory.
        step();
        at_neg();
        check("fetch_mem_read", {31'd0, mem_read}, 32'd1);
        check("fetch_mem_write", {31'd0, mem_write}, 32'd0);
        check("fetch_mem_address", {16'd0, mem_address}, 32'h0040);
        check("fetch_mem_be", {30'd0, mem_byte_enable}, 32'd3);
        push(1'b0, 1'b1, 16'h1234);
        step();
        at_neg();
        check("fetch_wait_resp", {30'd0, i_resp, d_resp}, 32'd0);
        step();
        mem_resp  = 1'b1;
        mem_rdata = 16'h1234;
        at_neg();
        expect_resp("fetch");
        step();
        mem_resp  = 1'b0;
        mem_rdata = 16'h0000;
        i_read    = 1'b0;
        at_neg();
        check("fetch_idle_read", {31'd0, mem_read}, 32'd0);
        check("fetch_resp_pulse", {30'd0, i_resp, d_resp}, 32'd0);

        // Byte-masked write to 0x8002.
        step();
        d_write       = 1'b1;
        d_address     = 16'h8002;
        d_wdata       = 16'hBEEF;
        d_byte_enable = 2'b10;
        step();
        at_neg();
        check("wr_mem_write", {31'd0, mem_write}, 32'd1);
        check("wr_mem_read", {31'd0, mem_read}, 32'd0);
        check("wr_mem_address", {16'd0, mem_address}, 32'h8002);
        check("wr_mem_wdata", {16'd0, mem_wdata}, 32'hBEEF);
        check("wr_mem_be", {30'd0, mem_byte_enable}, 32'd2);
        push(1'b1, 1'b0, 16'h0000);
        step();
        mem_resp = 1'b1;
        at_neg();
        expect_resp("wr");
        if (mem_write && mem_resp && mem_address == 16'h8002) begin
            for (int b = 0; b < int'(BE_W); b++) begin
                if (mem_byte_enable[b]) mem_word[b*8 +: 8] = mem_wdata[b*8 +: 8];
            end
        end
        check("wr_mem_word", {16'd0, mem_word}, 32'hBE55);
        step();
        mem_resp = 1'b0;
        d_write  = 1'b0;
        at_neg();
        check("wr_idle_write", {31'd0, mem_write}, 32'd0);

        // Tie from reset: both held high, grants alternate D, I, D, I.
        step();
        rst       = 1'b1;
        i_read    = 1'b1;
        i_address = 16'h0100;
        d_read    = 1'b1;
        d_address = 16'h0200;
        step();
        rst = 1'b0;
        for (int g = 0; g < 4; g++) begin
            bit          exp_d;
            logic [15:0] dat;
            exp_d = (g % 2 == 0);
            dat   = 16'hA000 + 16'(g);
            step();
            at_neg();
            check($sformatf("tie%0d_mem_read", g), {31'd0, mem_read}, 32'd1);
            check($sformatf("tie%0d_mem_address", g), {16'd0, mem_address},
                  exp_d ? 32'h0200 : 32'h0100);
            push(exp_d, 1'b1, dat);
            step();
            mem_resp  = 1'b1;
            mem_rdata = dat;
            at_neg();
            expect_resp($sformatf("tie%0d", g));
            step();
            mem_resp  = 1'b0;
            mem_rdata = 16'h0000;
            at_neg();
            check($sformatf("tie%0d_idle", g), {31'd0, mem_read}, 32'd0);
        end
        i_read = 1'b0;
        d_read = 1'b0;
        step();

        // Latched address holds while the requester changes its inputs.
        d_read    = 1'b1;
        d_address = 16'h1000;
        step();
        at_neg();
        check("latch_addr0", {16'd0, mem_address}, 32'h1000);
        push(1'b1, 1'b1, 16'h5A5A);
        step();
        d_address = 16'h2000;
        at_neg();
        check("latch_addr1", {16'd0, mem_address}, 32'h1000);
        step();
        mem_resp  = 1'b1;
        mem_rdata = 16'h5A5A;
        at_neg();
        check("latch_addr2", {16'd0, mem_address}, 32'h1000);
        expect_resp("latch");
        step();
        mem_resp  = 1'b0;
        mem_rdata = 16'h0000;
        d_read    = 1'b0;

        // Read and write together behave as a write.
        step();
        d_read    = 1'b1;
        d_write   = 1'b1;
        d_address = 16'h4000;
        step();
        at_neg();
        check("rw_mem_write", {31'd0, mem_write}, 32'd1);
        check("rw_mem_read", {31'd0, mem_read}, 32'd0);
        push(1'b1, 1'b0, 16'h0000);
        step();
        mem_resp = 1'b1;
        at_neg();
        expect_resp("rw");
        step();
        mem_resp = 1'b0;
        d_read   = 1'b0;
        d_write  = 1'b0;

        // Reset mid-write abandons the access; a late mem_resp is ignored.
        step();
        d_write   = 1'b1;
        d_address = 16'h3000;
        step();
        at_neg();
        check("rstmid_mem_write", {31'd0, mem_write}, 32'd1);
        step();
        rst     = 1'b1;
        d_write = 1'b0;
        step();
        rst      = 1'b0;
        mem_resp = 1'b1;
        at_neg();
        check("rstmid_write_off", {31'd0, mem_write}, 32'd0);
        check("rstmid_addr_clr", {16'd0, mem_address}, 32'd0);
        check("rstmid_no_resp", {30'd0, i_resp, d_resp}, 32'd0);
        step();
        mem_resp = 1'b0;
        at_neg();
        check("rstmid_no_resp2", {30'd0, i_resp, d_resp}, 32'd0);

        check("sb_drained", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
